// File: rtl/seg_display_pkg.sv
// Shared types and glyph table for the 7-segment display buffer.
package seg_display_pkg;

  typedef struct packed {
    logic       blank;
    logic [3:0] value;
  } digit_t;

  localparam logic [6:0] SEG_BLANK_AL = 7'h7F;

  // Active-high glyphs, bit order gfedcba; lowercase b and d.
  localparam logic [6:0] GLYPH_AH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational decoder from {blank, value} to a 7-segment pattern (gfedcba).
module hex_to_7seg
  import seg_display_pkg::*;
#(
  parameter bit ACTIVE_LOW_SEGS = 1'b1
) (
  input  logic       blank_i,
  input  logic [3:0] value_i,
  output logic [6:0] seg_o
);

  logic [6:0] seg_ah;

  always_comb begin
    seg_ah = blank_i ? 7'h00 : GLYPH_AH[value_i];
    seg_o  = ACTIVE_LOW_SEGS ? ~seg_ah : seg_ah;
  end

endmodule

// File: rtl/seg_display_buffer.sv
// Digit shift buffer with registered 7-segment outputs.
// Optional multiplexed scan outputs are built when SEG_SCAN_MUX_EN is defined.
module seg_display_buffer
  import seg_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS      = 6,
  parameter bit          ACTIVE_LOW_SEGS = 1'b1
`ifdef SEG_SCAN_MUX_EN
  , parameter int unsigned SCAN_DIV      = 50000
`endif
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [3:0]                        seg_data,
  input  logic                              seg_write,
  input  logic                              seg_shift,
  input  logic                              seg_clear,
  input  logic                              seg_off,
  output logic [7*NUM_DIGITS-1:0]           hex_out,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   fill_count,
  output logic                              full
`ifdef SEG_SCAN_MUX_EN
  , output logic [6:0]                      scan_seg,
  output logic [NUM_DIGITS-1:0]             scan_an
`endif
);

  localparam int unsigned CW = $clog2(NUM_DIGITS + 1);
  localparam logic [6:0]  SegDark = ACTIVE_LOW_SEGS ? SEG_BLANK_AL : 7'h00;
  localparam digit_t      DigBlank = '{blank: 1'b1, value: 4'h0};

  digit_t                  dig_q [NUM_DIGITS];
  digit_t                  dig_d [NUM_DIGITS];
  logic [CW-1:0]           fill_q, fill_d;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  logic                    full_q, full_d;
  logic [6:0]              seg_w [NUM_DIGITS];

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    hex_to_7seg #(
      .ACTIVE_LOW_SEGS(ACTIVE_LOW_SEGS)
    ) u_dec (
      .blank_i(dig_q[g].blank),
      .value_i(dig_q[g].value),
      .seg_o  (seg_w[g])
    );
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_DIGITS; i++) dig_d[i] = dig_q[i];
    if (seg_clear) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) dig_d[i] = DigBlank;
    end else begin
      if (seg_shift) begin
        for (int unsigned i = 1; i < NUM_DIGITS; i++) dig_d[i] = dig_q[i-1];
        dig_d[0] = DigBlank;
      end
      // A simultaneous write lands in the slot the shift just vacated.
      if (seg_write) dig_d[0] = '{blank: 1'b0, value: seg_data};
    end

    fill_d = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!dig_d[i].blank) fill_d = fill_d + CW'(1);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      hex_d[7*i +: 7] = seg_off ? SegDark : seg_w[i];
    end
    full_d = (fill_q == CW'(NUM_DIGITS));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) dig_q[i] <= DigBlank;
      fill_q <= '0;
      hex_q  <= {NUM_DIGITS{SegDark}};
      full_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) dig_q[i] <= dig_d[i];
      fill_q <= fill_d;
      hex_q  <= hex_d;
      full_q <= full_d;
    end
  end

  assign hex_out    = hex_q;
  assign fill_count = fill_q;
  assign full       = full_q;

`ifdef SEG_SCAN_MUX_EN
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] AnOff = ACTIVE_LOW_SEGS ? '1 : '0;

  logic [DIV_W-1:0]      div_q, div_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [6:0]            scan_seg_q, scan_seg_d;
  logic [NUM_DIGITS-1:0] scan_an_q, scan_an_d;
  logic [NUM_DIGITS-1:0] an_onehot;

  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    an_onehot = '0;
    an_onehot[idx_q] = 1'b1;
    scan_an_d  = seg_off ? AnOff : (ACTIVE_LOW_SEGS ? ~an_onehot : an_onehot);
    scan_seg_d = seg_off ? SegDark : seg_w[idx_q];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q      <= '0;
      idx_q      <= '0;
      scan_seg_q <= SegDark;
      scan_an_q  <= AnOff;
    end else begin
      div_q      <= div_d;
      idx_q      <= idx_d;
      scan_seg_q <= scan_seg_d;
      scan_an_q  <= scan_an_d;
    end
  end

  assign scan_seg = scan_seg_q;
  assign scan_an  = scan_an_q;
`endif

endmodule

// File: tb/tb_seg_display_buffer.sv
// Directed bench for seg_display_buffer (6 digits, active-low segments).
module tb_seg_display_buffer;

  localparam int N = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     seg_data;
  logic           seg_write, seg_shift, seg_clear, seg_off;
  logic [7*N-1:0] hex_out;
  logic [2:0]     fill_count;
  logic           full;
`ifdef SEG_SCAN_MUX_EN
  logic [6:0]     scan_seg;
  logic [N-1:0]   scan_an;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [7*N-1:0] AllDark = {N{7'h7F}};

  seg_display_buffer #(
    .NUM_DIGITS     (N),
    .ACTIVE_LOW_SEGS(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_data  (seg_data),
    .seg_write (seg_write),
    .seg_shift (seg_shift),
    .seg_clear (seg_clear),
    .seg_off   (seg_off),
    .hex_out   (hex_out),
    .fill_count(fill_count),
    .full      (full)
`ifdef SEG_SCAN_MUX_EN
    , .scan_seg(scan_seg),
    .scan_an   (scan_an)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    seg_write = 1'b0;
    seg_shift = 1'b0;
    seg_clear = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    seg_data = 4'h0;
    seg_off = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b1;
    check("reset_hex", 64'(hex_out), 64'(AllDark));
    check("reset_fill", 64'(fill_count), 64'd0);
    check("reset_full", 64'(full), 64'd0);

    // Single write of 9: count updates at once, display one edge later.
    seg_data = 4'h9;
    seg_write = 1'b1;
    tick();
    idle();
    check("write9_fill", 64'(fill_count), 64'd1);
    check("write9_hex_latency", 64'(hex_out), 64'(AllDark));
    tick();
    check("write9_hex", 64'(hex_out), 64'({{5{7'h7F}}, 7'h10}));

    // Scroll in 9,8,7,6,5,4; the first 9 falls off the left end.
    for (int d = 9; d >= 4; d--) begin
      seg_data = 4'(d);
      seg_shift = 1'b1;
      seg_write = 1'b1;
      tick();
    end
    idle();
    check("scroll6_fill", 64'(fill_count), 64'd6);
    tick();
    check("scroll6_hex", 64'(hex_out),
          64'({7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19}));
    check("scroll6_full", 64'(full), 64'd1);

    seg_data = 4'h3;
    seg_shift = 1'b1;
    seg_write = 1'b1;
    tick();
    idle();
    check("scroll3_fill", 64'(fill_count), 64'd6);
    tick();
    check("scroll3_hex", 64'(hex_out),
          64'({7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30}));
    check("scroll3_full", 64'(full), 64'd1);

    // Shift alone drops a lit digit and leaves digit 0 blank.
    seg_shift = 1'b1;
    tick();
    idle();
    check("shift_fill", 64'(fill_count), 64'd5);
    tick();
    check("shift_hex", 64'(hex_out),
          64'({7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h7F}));
    check("shift_full", 64'(full), 64'd0);

    // Clear wins over a simultaneous write.
    seg_data = 4'hA;
    seg_clear = 1'b1;
    seg_write = 1'b1;
    tick();
    idle();
    check("clear_fill", 64'(fill_count), 64'd0);
    tick();
    check("clear_hex", 64'(hex_out), 64'(AllDark));

    // Output forced dark while off; a write is still stored.
    seg_off = 1'b1;
    tick();
    check("off_hex0", 64'(hex_out), 64'(AllDark));
    seg_data = 4'hF;
    seg_write = 1'b1;
    tick();
    idle();
    check("off_fill", 64'(fill_count), 64'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("off_hex", 64'(hex_out), 64'(AllDark));
    end
    seg_off = 1'b0;
    tick();
    check("on_hex", 64'(hex_out), 64'({{5{7'h7F}}, 7'h0E}));

    // Reset overrides a simultaneous write.
    rst = 1'b0;
    seg_data = 4'h5;
    seg_write = 1'b1;
    tick();
    rst = 1'b1;
    idle();
    check("rst_mid_fill", 64'(fill_count), 64'd0);
    check("rst_mid_hex", 64'(hex_out), 64'(AllDark));
    tick();
    check("rst_mid_hex2", 64'(hex_out), 64'(AllDark));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_display_buffer.md
Name: seg_display_buffer

Overview:
Downstream stage of the scrolling controller. Consumes its seg_data/seg_write/seg_shift/seg_clear/seg_off command strobes and holds a NUM_DIGITS-wide digit shift buffer. Decodes the buffer to 7-segment patterns that drive the board HEX displays. New characters enter at digit 0 (rightmost) and scroll left on each shift.

Parameters:
NUM_DIGITS, 6, number of physical 7-segment digits; legal range 2..8.
ACTIVE_LOW_SEGS, 1, 1 = segment lit when bit is 0 (board HEX); 0 = active-high.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  synchronous, active-low reset.
seg_data  in  4  hex nibble to write into digit 0.
seg_write  in  1  single-cycle strobe: load seg_data into digit 0, unblank it.
seg_shift  in  1  single-cycle strobe: shift buffer one digit left.
seg_clear  in  1  single-cycle strobe: blank every digit.
seg_off  in  1  level: 1 = force all outputs dark; storage retained.
hex_out  out  7*NUM_DIGITS  decoded segments, digit i at bits [7i+6:7i], bit order gfedcba.
fill_count  out  $clog2(NUM_DIGITS+1)  number of non-blank digits currently stored.
full  out  1  fill_count == NUM_DIGITS.

Behaviour:
- Storage: digit_t array dig[0..NUM_DIGITS-1]; each entry = {blank, value[3:0]}. dig[0] is rightmost.
- Reset (rst==0 at an edge): every dig = {1, 0}; hex_out = all segments dark (all 1s when ACTIVE_LOW_SEGS=1, else all 0s); fill_count = 0; full = 0.
- Command priority within one cycle: clear > (shift, write) > hold.
- seg_clear: all dig blanked, fill_count -> 0. Shift/write in the same cycle are ignored.
- seg_shift alone: dig[i+1] <= dig[i] for i = 0..N-2; dig[N-1] is discarded; dig[0] <= blank.
- seg_write alone: dig[0] <= {0, seg_data}; other digits unchanged. Overwriting an already non-blank dig[0] does not change the count.
- seg_shift and seg_write together: shift, then dig[0] <= {0, seg_data} in the same edge. This is the scroll-in case.
- fill_count: registered; recomputed from next-state storage, so it is always consistent with dig. Saturation is implicit (max NUM_DIGITS). Shifting out a non-blank dig[N-1] reduces the count.
- Latency: a command sampled at edge t updates dig at t. hex_out and full reflect it after edge t+1 (registered output stage). fill_count updates at t.
- seg_off: sampled into the output register. While 1, hex_out is all-dark at the next edge and dig is unaffected. Commands are still accepted while off. Deasserting seg_off restores the current contents one edge later.
- Blank digits decode to all-dark regardless of value.
- Decode 0..F: standard hex glyphs with lowercase b and d. Active-low values: 0=0x40, 1=0x79, 8=0x00, 9=0x10, A=0x08, F=0x0E, blank=0x7F.
- Reset mid-operation overrides any simultaneous strobe.

Optional Feature:
SEG_SCAN_MUX_EN.
- Defined: adds parameter SCAN_DIV (default 50000) and output ports scan_seg[6:0] and scan_an[NUM_DIGITS-1:0].
  - A divider counter advances a digit index every SCAN_DIV clocks, wrapping at NUM_DIGITS-1 -> 0.
  - scan_an is one-hot for the current index, active-low when ACTIVE_LOW_SEGS=1; scan_seg carries that digit's pattern.
  - seg_off forces scan_an all inactive.
  - Reset: index 0, divider 0, scan_an all inactive for one cycle.
- Undefined: these ports, the parameter and the counter do not exist; hex_out only.

Decomposition:
- Package seg_display_pkg holds:
  - digit_t packed struct {blank, value[3:0]}.
  - SEG_BLANK_AL constant (7'h7F).
  - Active-high glyph constant table for 0..F.
- Sub-module hex_to_7seg: combinational {blank, value} -> 7-bit pattern with polarity parameter. Instantiated NUM_DIGITS times in a generate loop.

Test Plan:
- Reset held 2 cycles, then released -> hex_out = all 0x7F, fill_count=0, full=0.
- seg_write with seg_data=9 -> after 2 edges hex_out[6:0]=0x10, other digits 0x7F, fill_count=1.
- Six cycles of shift+write with data 9,8,7,6,5,4 -> digit5..0 show 9,8,7,6,5,4, full=1. One more shift+write with data 3 -> 9 discarded, digit0=3, full still 1.
- seg_clear pulsed together with seg_write (data=A) -> all digits 0x7F, fill_count=0; the write is ignored.
- seg_off=1 for 5 cycles with a seg_write (data=F) during it -> hex_out dark throughout; after release, digit0=0x0E.
- SEG_SCAN_MUX_EN, SCAN_DIV=4, buffer 0..5 -> scan_an cycles one-hot every 4 clocks, wraps after digit 5, scan_seg matches the decoded digit.
